// File: rtl/run_seq_pkg.sv
// Shared FSM encoding and default parameter constants for the run sequencer.
package run_seq_pkg;

  localparam int unsigned DEF_RESET_CYCLES = 1;
  localparam int unsigned DEF_RUN_CYCLES   = 50;
  localparam int unsigned DEF_NUM_RUNS     = 2;
  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_RUNS_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/run_sequencer_if.sv
// Control/status bundle between a host (master) and the run sequencer (slave).
interface run_sequencer_if
  import run_seq_pkg::*;
#(
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned RUNS_W = DEF_RUNS_W
) ();

  logic              start;
  logic              halt;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic [RUNS_W-1:0] run_idx;
  logic [CNT_W-1:0]  cycles;
  logic              timeout;

  modport master (
    output start, halt,
    input  core_reset, busy, done, run_idx, cycles, timeout
  );

  modport slave (
    input  start, halt,
    output core_reset, busy, done, run_idx, cycles, timeout
  );

endinterface

// File: rtl/seq_counter.sv
// Up-counter with synchronous clear (priority) and enable; times both RST and RUN.
module seq_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins over enable.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/run_sequencer.sv
// Sequences NUM_RUNS reset+run passes of a core, timing each run against a budget.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned RUN_CYCLES   = DEF_RUN_CYCLES,
  parameter int unsigned NUM_RUNS     = DEF_NUM_RUNS,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned RUNS_W       = DEF_RUNS_W
) (
  input logic            clk,
  input logic            reset,
  run_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST = CNT_W'(RUN_CYCLES - 1);
  localparam logic [RUNS_W-1:0] IDX_LAST = RUNS_W'(NUM_RUNS - 1);

  seq_state_e        state_q, state_d;
  logic [RUNS_W-1:0] run_idx_q, run_idx_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic              timeout_q, timeout_d;
  logic              core_reset_q, core_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  cnt;
  logic              cnt_clr;
  logic              cnt_en;

  seq_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt)
  );

  // Next-state, run bookkeeping and counter control; status flags decoded from the next state.
  always_comb begin
    state_d   = state_q;
    run_idx_d = run_idx_q;
    cycles_d  = cycles_q;
    timeout_d = timeout_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (bus.start) begin
          timeout_d = 1'b0;
          run_idx_d = '0;
          state_d   = ST_RST;
        end
      end
      ST_RST: begin
        if (cnt == RST_LAST) begin
          cnt_clr = 1'b1;
          state_d = ST_RUN;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.halt || (cnt == RUN_LAST)) begin
          // On the limit cycle cnt+1 equals RUN_CYCLES, so one expression covers both endings.
          cnt_clr  = 1'b1;
          cycles_d = cnt + CNT_W'(1);
          if (!bus.halt) begin
            timeout_d = 1'b1;
          end
          if (run_idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            run_idx_d = run_idx_q + RUNS_W'(1);
            state_d   = ST_RST;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    core_reset_d = (state_d != ST_RUN);
    busy_d       = (state_d == ST_RST) || (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      run_idx_q    <= '0;
      cycles_q     <= '0;
      timeout_q    <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_idx_q    <= run_idx_d;
      cycles_q     <= cycles_d;
      timeout_q    <= timeout_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.core_reset = core_reset_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.run_idx    = run_idx_q;
  assign bus.cycles     = cycles_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: three parameterisations, directed and random halt plans.
module tb_run_sequencer;

  localparam int unsigned NDUT = 3;
  localparam int unsigned CW   = 16;
  localparam int unsigned RW   = 8;

  typedef struct {
    int dut;
    int a;
    int b;
    int c;
  } exp_t;

  function automatic int p_res(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int p_run(input int k);
    case (k)
      0:       return 50;
      1:       return 5;
      default: return 7;
    endcase
  endfunction

  function automatic int p_num(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  run_sequencer_if #(.CNT_W(CW), .RUNS_W(RW)) if_a ();
  run_sequencer_if #(.CNT_W(CW), .RUNS_W(RW)) if_b ();
  run_sequencer_if #(.CNT_W(CW), .RUNS_W(RW)) if_c ();

  run_sequencer #(.RESET_CYCLES(1), .RUN_CYCLES(50), .NUM_RUNS(2), .CNT_W(CW), .RUNS_W(RW))
    u_dut_a (.clk(clk), .reset(reset), .bus(if_a));
  run_sequencer #(.RESET_CYCLES(3), .RUN_CYCLES(5), .NUM_RUNS(1), .CNT_W(CW), .RUNS_W(RW))
    u_dut_b (.clk(clk), .reset(reset), .bus(if_b));
  run_sequencer #(.RESET_CYCLES(2), .RUN_CYCLES(7), .NUM_RUNS(3), .CNT_W(CW), .RUNS_W(RW))
    u_dut_c (.clk(clk), .reset(reset), .bus(if_c));

  logic [NDUT-1:0] st = '0;
  logic [NDUT-1:0] ht = '0;
  logic [NDUT-1:0] cr, bz, dn, to;
  logic [RW-1:0]   ri [NDUT];
  logic [CW-1:0]   cy [NDUT];

  assign if_a.start = st[0];
  assign if_a.halt  = ht[0];
  assign if_b.start = st[1];
  assign if_b.halt  = ht[1];
  assign if_c.start = st[2];
  assign if_c.halt  = ht[2];

  assign cr[0] = if_a.core_reset;
  assign bz[0] = if_a.busy;
  assign dn[0] = if_a.done;
  assign to[0] = if_a.timeout;
  assign ri[0] = if_a.run_idx;
  assign cy[0] = if_a.cycles;
  assign cr[1] = if_b.core_reset;
  assign bz[1] = if_b.busy;
  assign dn[1] = if_b.done;
  assign to[1] = if_b.timeout;
  assign ri[1] = if_b.run_idx;
  assign cy[1] = if_b.cycles;
  assign cr[2] = if_c.core_reset;
  assign bz[2] = if_c.busy;
  assign dn[2] = if_c.done;
  assign to[2] = if_c.timeout;
  assign ri[2] = if_c.run_idx;
  assign cy[2] = if_c.cycles;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q_win[$];
  exp_t q_done[$];

  logic [NDUT-1:0] start_req = '0;
  int   plan [NDUT][3];
  int   run_no  [NDUT];
  int   run_cyc [NDUT];
  int   lo_cnt  [NDUT];
  int   hi_cnt  [NDUT];
  logic [NDUT-1:0] prev_cr = '1;
  logic [NDUT-1:0] prev_dn = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stimulus driver: halt on the planned RUN cycle, random halt noise outside RUN, random start while busy.
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < NDUT; k++) begin
      if (start_req[k]) run_no[k] = -1;
      if (!cr[k]) begin
        if (run_cyc[k] == 0) run_no[k]++;
        run_cyc[k]++;
        ht[k] = (run_no[k] >= 0) && (run_no[k] < 3) && (plan[k][run_no[k]] == run_cyc[k]);
      end else begin
        run_cyc[k] = 0;
        ht[k] = 1'($urandom_range(0, 1));
      end
      st[k] = start_req[k] | (bz[k] & 1'($urandom_range(0, 1)));
    end
  end

  // Monitor: measures core_reset windows and checks every done pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NDUT; k++) begin
      if (!reset) begin
        lo_cnt[k]  = 0;
        hi_cnt[k]  = 0;
        prev_cr[k] = 1'b1;
        prev_dn[k] = 1'b0;
      end else begin
        if (cr[k] && !prev_cr[k]) begin
          if (q_win.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL d%0d_win_unexpected: low window of %0d cycles, none expected", k, lo_cnt[k]);
          end else begin
            e = q_win.pop_front();
            check($sformatf("d%0d_win_dut", k), 64'(k), 64'(e.dut));
            check($sformatf("d%0d_run_len", k), 64'(lo_cnt[k]), 64'(e.a));
            check($sformatf("d%0d_rst_len", k), 64'(hi_cnt[k]), 64'(e.b));
          end
          lo_cnt[k] = 0;
          hi_cnt[k] = 0;
        end
        if (!cr[k]) lo_cnt[k]++;
        else if (bz[k]) hi_cnt[k]++;
        if (dn[k]) begin
          check($sformatf("d%0d_done_width", k), 64'(prev_dn[k]), 64'd0);
          if (q_done.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL d%0d_done_unexpected: done=1 expected 0", k);
          end else begin
            e = q_done.pop_front();
            check($sformatf("d%0d_done_dut", k), 64'(k), 64'(e.dut));
            check($sformatf("d%0d_run_idx", k), 64'(ri[k]), 64'(e.a));
            check($sformatf("d%0d_cycles", k), 64'(cy[k]), 64'(e.b));
            check($sformatf("d%0d_timeout", k), 64'(to[k]), 64'(e.c));
            check($sformatf("d%0d_done_busy", k), 64'(bz[k]), 64'd0);
            check($sformatf("d%0d_done_core_reset", k), 64'(cr[k]), 64'd1);
          end
        end
        prev_cr[k] = cr[k];
        prev_dn[k] = dn[k];
      end
    end
  end

  task automatic check_reset_vals(input int k);
    check($sformatf("d%0d_rst_core_reset", k), 64'(cr[k]), 64'd1);
    check($sformatf("d%0d_rst_busy", k), 64'(bz[k]), 64'd0);
    check($sformatf("d%0d_rst_done", k), 64'(dn[k]), 64'd0);
    check($sformatf("d%0d_rst_run_idx", k), 64'(ri[k]), 64'd0);
    check($sformatf("d%0d_rst_cycles", k), 64'(cy[k]), 64'd0);
    check($sformatf("d%0d_rst_timeout", k), 64'(to[k]), 64'd0);
  endtask

  // One sequence on DUT k; halt plan per run (0 = never halt, n = halt on RUN cycle n).
  task automatic run_seq(input int k, input int h0, input int h1, input int h2);
    int   h [3];
    int   len;
    int   last;
    int   tmo;
    int   i;
    exp_t e;
    h[0] = h0;
    h[1] = h1;
    h[2] = h2;
    @(posedge clk);
    #1;
    tmo  = 0;
    last = 0;
    for (int r = 0; r < 3; r++) plan[k][r] = h[r];
    for (int r = 0; r < p_num(k); r++) begin
      len = (h[r] == 0) ? p_run(k) : h[r];
      if (h[r] == 0) tmo = 1;
      last = len;
      e.dut = k;
      e.a   = len;
      e.b   = p_res(k);
      e.c   = 0;
      q_win.push_back(e);
    end
    e.dut = k;
    e.a   = p_num(k) - 1;
    e.b   = last;
    e.c   = tmo;
    q_done.push_back(e);
    start_req[k] = 1'b1;
    @(posedge clk);
    #1;
    start_req[k] = 1'b0;
    i = 0;
    while (q_done.size() != 0 && i < 3000) begin
      @(posedge clk);
      i++;
    end
    check($sformatf("d%0d_done_pending", k), 64'(q_done.size()), 64'd0);
    check($sformatf("d%0d_windows_pending", k), 64'(q_win.size()), 64'd0);
    q_done.delete();
    q_win.delete();
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("d%0d_hold_run_idx", k), 64'(ri[k]), 64'(p_num(k) - 1));
    check($sformatf("d%0d_hold_cycles", k), 64'(cy[k]), 64'(last));
    check($sformatf("d%0d_hold_timeout", k), 64'(to[k]), 64'(tmo));
    check($sformatf("d%0d_hold_idle", k), 64'({bz[k], cr[k], dn[k]}), 64'b010);
  endtask

  function automatic int pick_halt(input int k);
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 1;
      2:       return p_run(k);
      3:       return (p_run(k) > 1) ? p_run(k) - 1 : 1;
      default: return int'($urandom_range(1, p_run(k)));
    endcase
  endfunction

  initial begin
    int i;
    int k;
    reset = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      for (int r = 0; r < 3; r++) plan[d][r] = 0;
      run_no[d]  = 0;
      run_cyc[d] = 0;
      lo_cnt[d]  = 0;
      hi_cnt[d]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) check_reset_vals(d);
    @(posedge clk);
    #3;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Default config: full timeouts, halt on cycle 10, halt exactly on the limit cycle, mixed.
    run_seq(0, 0, 0, 0);
    run_seq(0, 10, 10, 0);
    run_seq(0, 50, 50, 0);
    run_seq(0, 50, 0, 0);
    run_seq(0, 1, 49, 0);
    // Short config: single run, three reset cycles, five-cycle budget.
    run_seq(1, 0, 0, 0);
    run_seq(1, 5, 0, 0);
    // Three-run config.
    run_seq(2, 3, 0, 7);

    // Abort with reset on RUN cycle 20 of run 0, then restart.
    @(posedge clk);
    #1;
    plan[0][0] = 0;
    plan[0][1] = 0;
    start_req[0] = 1'b1;
    @(posedge clk);
    #1;
    start_req[0] = 1'b0;
    i = 0;
    do begin
      @(posedge clk);
      #3;
      i++;
    end while (run_cyc[0] != 20 && i < 500);
    check("d0_abort_reached_cycle20", 64'(run_cyc[0]), 64'd20);
    reset = 1'b0;
    #1;
    check_reset_vals(0);
    repeat (3) @(posedge clk);
    #3;
    check_reset_vals(0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("d0_idle_after_abort", 64'({bz[0], cr[0], dn[0]}), 64'b010);
    run_seq(0, 7, 0, 0);

    // Random plans across all configurations.
    for (int it = 0; it < 24; it++) begin
      k = int'($urandom_range(0, NDUT - 1));
      run_seq(k, pick_halt(k), pick_halt(k), pick_halt(k));
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 1: cycles core_reset is held high before each run; legal range >= 1.
REQ-002 Parameter RUN_CYCLES, default 50: per-run cycle budget before timeout; legal range >= 1 and < 2^CNT_W.
REQ-003 Parameter NUM_RUNS, default 2: number of reset+run passes per start; legal range 1 to 2^RUNS_W.
REQ-004 Parameter CNT_W, default 16: width of the run-cycle counter and the cycles output.
REQ-005 Parameter RUNS_W, default 8: width of run_idx.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-008 start  in  1  request a sequence; sampled only in IDLE.
REQ-009 halt  in  1  DUT signals program end; sampled only in RUN.
REQ-010 core_reset  out  1  active-high reset to the DUT core.
REQ-011 busy  out  1  high in states RST and RUN.
REQ-012 done  out  1  one-cycle pulse when a sequence completes.
REQ-013 run_idx  out  RUNS_W  index of the current or last run, 0-based.
REQ-014 cycles  out  CNT_W  RUN-cycle count of the most recently finished run.
REQ-015 timeout  out  1  sticky; set if any run in the sequence reached RUN_CYCLES without halt.

Function
REQ-016 FSM states SHALL be IDLE, RST, RUN and DONE.
REQ-017 core_reset SHALL be 1 in IDLE, RST and DONE, and 0 only in RUN.
REQ-018 In IDLE with start=1: clear timeout, run_idx=0 and counter=0, then go to RST on the next edge; start=0 stays in IDLE.
REQ-019 start in any state other than IDLE SHALL be ignored with no effect.
REQ-020 RST SHALL last exactly RESET_CYCLES cycles, then go to RUN with counter=0.
REQ-021 In RUN, the counter SHALL increment by 1 each cycle; a run ends on halt=1 or when counter == RUN_CYCLES-1.
REQ-022 On halt in RUN: cycles = counter+1 and timeout is unchanged.
REQ-023 On the budget limit without halt: cycles = RUN_CYCLES and timeout = 1.
REQ-024 If halt=1 on the limit cycle, halt SHALL take priority: no timeout, and cycles = RUN_CYCLES.
REQ-025 At run end: if run_idx == NUM_RUNS-1 go to DONE; otherwise increment run_idx and go to RST.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE; run_idx, cycles and timeout SHALL hold until the next start.
REQ-027 halt outside RUN SHALL be ignored.
REQ-028 The counter SHALL never wrap, because of the legal range in REQ-002.

Reset
REQ-029 While reset=0, outputs SHALL be: state=IDLE, core_reset=1, busy=0, done=0, run_idx=0, cycles=0, timeout=0, counter=0.
REQ-030 Asserting reset mid-RST or mid-RUN SHALL abort the sequence immediately with no done pulse.
REQ-031 After reset deasserts, the block SHALL wait in IDLE for start.

Structure
REQ-032 FSM state encodings and default parameter constants SHALL live in the shared package/header run_seq_pkg.
REQ-033 One sub-module, seq_counter (a CNT_W-bit counter with clear and enable), SHALL implement both the RST and RUN counting.

Verification
REQ-034 Default parameters, halt held 0, one start pulse -> two core_reset-low windows of 50 cycles each, each preceded by 1 cycle of core_reset high; then timeout=1, cycles=50, run_idx=1, and done pulses exactly once.
REQ-035 Default parameters, halt=1 on the 10th RUN cycle of each run -> cycles=10, timeout=0, done after run 1.
REQ-036 halt=1 exactly on RUN cycle 50 -> cycles=50 and timeout=0 (halt priority).
REQ-037 reset=0 at RUN cycle 20 of run 0 -> all outputs at reset values asynchronously, no done pulse; a later start restarts from run_idx=0.
REQ-038 start pulsed during RUN -> no effect on state, counter or run_idx.
REQ-039 NUM_RUNS=1, RESET_CYCLES=3, RUN_CYCLES=5 -> core_reset high for 3 cycles, low for 5 cycles; then timeout=1, cycles=5, done pulses, run_idx=0.
